// File: rtl/pcileech_dna_gate.sv
// Device-identity gate: reads the FPGA DNA serially through DNA_PORT, compares it
// against a list of allowed IDs and drives the COM enable, status and fault LED.
module pcileech_dna_gate #(
    parameter int                           DNA_WIDTH = 57,
    parameter int                           NUM_IDS   = 4,
    parameter logic [NUM_IDS*DNA_WIDTH-1:0] ID_LIST   = {NUM_IDS*DNA_WIDTH{1'b0}},
    parameter logic [DNA_WIDTH-1:0]         ID_MASK   = {DNA_WIDTH{1'b1}},
    parameter int                           CLK_DIV   = 2,
    parameter int                           ENFORCE   = 1,
    parameter int                           LOCKOUT   = 0,
    parameter int                           BLINK_BIT = 24,
    localparam int                          IDX_W     = (NUM_IDS > 1) ? $clog2(NUM_IDS) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    output logic                 dna_clk_o,
    output logic                 dna_read_o,
    output logic                 dna_shift_o,
    input  logic                 dna_dout_i,
    output logic [DNA_WIDTH-1:0] dna_value,
    output logic                 dna_valid,
    output logic                 id_match,
    output logic [IDX_W-1:0]     match_index,
    output logic                 busy,
    output logic                 com_enable,
    output logic                 led_fault
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BIT_W = $clog2(DNA_WIDTH + 1);
    localparam int BLK_W = BLINK_BIT + 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DNA_WIDTH - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_IDS - 1);

    typedef enum logic [2:0] {ST_IDLE, ST_LOAD, ST_SHIFT, ST_CMP, ST_DONE} state_t;

    state_t               state_q, state_d;
    logic [DIV_W-1:0]     div_q, div_d;
    logic                 dna_clk_q, dna_clk_d;
    logic [BIT_W-1:0]     bit_q, bit_d;
    logic [DNA_WIDTH-1:0] sr_q, sr_d;
    logic [DNA_WIDTH-1:0] dna_value_q, dna_value_d;
    logic                 dna_valid_q, dna_valid_d;
    logic [IDX_W-1:0]     cmp_idx_q, cmp_idx_d;
    logic                 id_match_q, id_match_d;
    logic [IDX_W-1:0]     match_index_q, match_index_d;
    logic                 com_enable_q, com_enable_d;
    logic                 lock_q, lock_d;
    logic                 auto_q, auto_d;
    logic [BLK_W-1:0]     blink_q, blink_d;

    // Masked copies of the allowed IDs so the compare is a plain equality.
    logic [DNA_WIDTH-1:0] id_tab [NUM_IDS];
    for (genvar gi = 0; gi < NUM_IDS; gi++) begin : g_id_tab
        assign id_tab[gi] = ID_LIST[gi*DNA_WIDTH +: DNA_WIDTH] & ID_MASK;
    end

    logic                 dclk_run, div_last, dclk_rise, dclk_fall;
    logic                 go_load, go_done, done_match, lock_next;
    logic [IDX_W-1:0]     done_idx;
    logic [DNA_WIDTH-1:0] masked;

    always_comb begin
        state_d       = state_q;
        div_d         = div_q;
        dna_clk_d     = dna_clk_q;
        bit_d         = bit_q;
        sr_d          = sr_q;
        dna_value_d   = dna_value_q;
        dna_valid_d   = dna_valid_q;
        cmp_idx_d     = cmp_idx_q;
        id_match_d    = id_match_q;
        match_index_d = match_index_q;
        com_enable_d  = com_enable_q;
        lock_d        = lock_q;
        auto_d        = auto_q;
        blink_d       = blink_q + BLK_W'(1);
        go_load       = 1'b0;
        go_done       = 1'b0;
        done_match    = 1'b0;
        done_idx      = '0;
        lock_next     = lock_q;
        masked        = dna_value_q & ID_MASK;

        dclk_run  = (state_q == ST_LOAD) || (state_q == ST_SHIFT);
        div_last  = (div_q == DIV_LAST);
        dclk_rise = dclk_run && !dna_clk_q && div_last;
        dclk_fall = dclk_run && dna_clk_q && div_last;

        if (dclk_run) begin
            if (div_last) begin
                div_d     = '0;
                dna_clk_d = ~dna_clk_q;
            end else begin
                div_d = div_q + DIV_W'(1);
            end
        end

        // State changes happen on DCLK falling edges, so READ/SHIFT move only in the low phase.
        case (state_q)
            ST_IDLE: if (auto_q || start) go_load = 1'b1;
            ST_LOAD: begin
                if (dclk_fall) begin
                    state_d = ST_SHIFT;
                    bit_d   = '0;
                end
            end
            ST_SHIFT: begin
                if (dclk_rise) sr_d = {sr_q[DNA_WIDTH-2:0], dna_dout_i};
                if (dclk_fall) begin
                    if (bit_q == BIT_LAST) begin
                        state_d     = ST_CMP;
                        dna_value_d = sr_q;
                        dna_valid_d = 1'b1;
                        cmp_idx_d   = '0;
                    end else begin
                        bit_d = bit_q + BIT_W'(1);
                    end
                end
            end
            ST_CMP: begin
                if (masked == id_tab[cmp_idx_q]) begin
                    go_done    = 1'b1;
                    done_match = 1'b1;
                    done_idx   = cmp_idx_q;
                end else if (cmp_idx_q == IDX_LAST) begin
                    go_done = 1'b1;
                end else begin
                    cmp_idx_d = cmp_idx_q + IDX_W'(1);
                end
            end
            ST_DONE: if (start) go_load = 1'b1;
            default: state_d = ST_IDLE;
        endcase

        if (go_load) begin
            state_d     = ST_LOAD;
            auto_d      = 1'b0;
            dna_valid_d = 1'b0;
            div_d       = '0;
            dna_clk_d   = 1'b0;
            bit_d       = '0;
        end

        // Results and the enable only move here, so a re-check never glitches com_enable.
        if (go_done) begin
            state_d       = ST_DONE;
            id_match_d    = done_match;
            match_index_d = done_idx;
            lock_next     = lock_q || ((LOCKOUT != 0) && !done_match);
            lock_d        = lock_next;
            com_enable_d  = !lock_next && ((ENFORCE == 0) || done_match);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            div_q         <= '0;
            dna_clk_q     <= 1'b0;
            bit_q         <= '0;
            sr_q          <= '0;
            dna_value_q   <= '0;
            dna_valid_q   <= 1'b0;
            cmp_idx_q     <= '0;
            id_match_q    <= 1'b0;
            match_index_q <= '0;
            com_enable_q  <= 1'b0;
            lock_q        <= 1'b0;
            auto_q        <= 1'b1;
            blink_q       <= '0;
        end else begin
            state_q       <= state_d;
            div_q         <= div_d;
            dna_clk_q     <= dna_clk_d;
            bit_q         <= bit_d;
            sr_q          <= sr_d;
            dna_value_q   <= dna_value_d;
            dna_valid_q   <= dna_valid_d;
            cmp_idx_q     <= cmp_idx_d;
            id_match_q    <= id_match_d;
            match_index_q <= match_index_d;
            com_enable_q  <= com_enable_d;
            lock_q        <= lock_d;
            auto_q        <= auto_d;
            blink_q       <= blink_d;
        end
    end

    assign dna_clk_o   = dna_clk_q;
    assign dna_read_o  = (state_q == ST_LOAD);
    assign dna_shift_o = (state_q == ST_SHIFT);
    assign busy        = (state_q == ST_LOAD) || (state_q == ST_SHIFT) || (state_q == ST_CMP);
    assign dna_value   = dna_value_q;
    assign dna_valid   = dna_valid_q;
    assign id_match    = id_match_q;
    assign match_index = match_index_q;
    assign com_enable  = com_enable_q;
    assign led_fault   = dna_valid_q & ~id_match_q & blink_q[BLINK_BIT];

endmodule

// File: tb/tb_pcileech_dna_gate.sv
// Bench for pcileech_dna_gate: three instances (lockout/enforce, report-only, masked)
// each fed by a behavioural DNA_PORT model.
module tb_pcileech_dna_gate;

    localparam logic [56:0] DNA_A = 57'h1AB_CDEF_0123_4567;
    localparam logic [56:0] DNA_B = 57'h0F0_F0F0_F0F0_F0F0;
    localparam logic [56:0] DNA_C = 57'h155_5555_5555_5555;
    localparam logic [56:0] DNA_Z = 57'h0DE_ADBE_EFCA_FE01;
    localparam logic [56:0] DNA_X = 57'h000_1111_2222_3333;
    localparam logic [4*57-1:0] LIST_A = {DNA_Z, DNA_A, DNA_C, DNA_X};
    localparam logic [4*57-1:0] LIST_M = {DNA_Z, DNA_Z, DNA_A, DNA_A ^ 57'hA5};
    localparam logic [56:0] MASK_M = {{49{1'b1}}, 8'h00};

    typedef struct {
        logic [56:0] model;
        logic        use_rst;
        logic        idm;
        logic [1:0]  idx;
        logic        com;
        int          cyc;
    } vec_t;

    typedef struct {
        logic [56:0] dna;
        logic        idm;
        logic [1:0]  idx;
        logic        com;
        int          cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst0 = 1'b1;
    logic rst_b = 1'b1;
    logic start0 = 1'b0;
    logic start_b = 1'b0;
    logic        dclk_w [3];
    logic        rd_w   [3];
    logic        sh_w   [3];
    logic        dout_w [3];
    logic [56:0] dv_w   [3];
    logic        valid_w[3];
    logic        idm_w  [3];
    logic [1:0]  idx_w  [3];
    logic        busy_w [3];
    logic        com_w  [3];
    logic        led_w  [3];
    logic [56:0] model_val [3];

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    int shift_rises = 0;
    exp_t exp_q[$];
    vec_t vecs[4];

    always #5 clk = ~clk;

    pcileech_dna_gate #(.DNA_WIDTH(57), .NUM_IDS(4), .ID_LIST(LIST_A), .ID_MASK({57{1'b1}}),
        .CLK_DIV(2), .ENFORCE(1), .LOCKOUT(1), .BLINK_BIT(4)) u_lock (
        .clk(clk), .rst(rst0), .start(start0),
        .dna_clk_o(dclk_w[0]), .dna_read_o(rd_w[0]), .dna_shift_o(sh_w[0]), .dna_dout_i(dout_w[0]),
        .dna_value(dv_w[0]), .dna_valid(valid_w[0]), .id_match(idm_w[0]), .match_index(idx_w[0]),
        .busy(busy_w[0]), .com_enable(com_w[0]), .led_fault(led_w[0]));

    pcileech_dna_gate #(.DNA_WIDTH(57), .NUM_IDS(4), .ID_LIST(LIST_A), .ID_MASK({57{1'b1}}),
        .CLK_DIV(2), .ENFORCE(0), .LOCKOUT(0), .BLINK_BIT(4)) u_report (
        .clk(clk), .rst(rst_b), .start(start_b),
        .dna_clk_o(dclk_w[1]), .dna_read_o(rd_w[1]), .dna_shift_o(sh_w[1]), .dna_dout_i(dout_w[1]),
        .dna_value(dv_w[1]), .dna_valid(valid_w[1]), .id_match(idm_w[1]), .match_index(idx_w[1]),
        .busy(busy_w[1]), .com_enable(com_w[1]), .led_fault(led_w[1]));

    pcileech_dna_gate #(.DNA_WIDTH(57), .NUM_IDS(4), .ID_LIST(LIST_M), .ID_MASK(MASK_M),
        .CLK_DIV(2), .ENFORCE(1), .LOCKOUT(0), .BLINK_BIT(4)) u_mask (
        .clk(clk), .rst(rst_b), .start(start_b),
        .dna_clk_o(dclk_w[2]), .dna_read_o(rd_w[2]), .dna_shift_o(sh_w[2]), .dna_dout_i(dout_w[2]),
        .dna_value(dv_w[2]), .dna_valid(valid_w[2]), .id_match(idm_w[2]), .match_index(idx_w[2]),
        .busy(busy_w[2]), .com_enable(com_w[2]), .led_fault(led_w[2]));

    // DNA_PORT model: READ loads the value on DCLK rise, SHIFT moves it out MSB first.
    for (genvar gi = 0; gi < 3; gi++) begin : g_model
        logic [56:0] sr;
        always @(posedge dclk_w[gi]) begin
            if (rd_w[gi]) sr <= model_val[gi];
            else if (sh_w[gi]) sr <= {sr[55:0], 1'b0};
        end
        assign dout_w[gi] = sr[56];
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic chk_range(input string name, input int act, input int lo, input int hi);
        checks++;
        if (act < lo || act > hi) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d..%0d", name, act, lo, hi);
        end
    endtask

    task automatic wait_done(input int base);
        for (int k = 0; k < 3000 && done_cnt <= base; k++) @(negedge clk);
        chk("done_timeout", (done_cnt > base) ? 1 : 0, 1);
    endtask

    task automatic count_toggles(input int u, output int n);
        logic p;
        n = 0;
        @(negedge clk);
        p = led_w[u];
        repeat (64) begin
            @(negedge clk);
            if (led_w[u] !== p) n++;
            p = led_w[u];
        end
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
    endtask

    // Monitor for u_lock: READ/SHIFT stability at DCLK rise, enable hold while busy,
    // and scoreboard pop on each completed check.
    initial begin
        logic busy_prev, dclk_prev, rd_prev, sh_prev, com_hold;
        int run_cyc;
        exp_t e;
        busy_prev = 0; dclk_prev = 0; rd_prev = 0; sh_prev = 0; com_hold = 0; run_cyc = 0;
        forever begin
            @(negedge clk);
            if (busy_w[0] && !busy_prev) begin
                run_cyc = 0;
                com_hold = com_w[0];
                shift_rises = 0;
            end
            if (!rst0 && dclk_w[0] && !dclk_prev) begin
                chk("rdsh_stable", {62'd0, rd_w[0], sh_w[0]}, {62'd0, rd_prev, sh_prev});
                if (sh_w[0]) shift_rises++;
            end
            if (busy_w[0]) begin
                run_cyc++;
                chk("com_hold", com_w[0], com_hold);
            end
            if (!busy_w[0] && busy_prev && !rst0) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done actual=1 required=0");
                end else begin
                    e = exp_q.pop_front();
                    $display("done %0d: dna=%h id_match=%0d idx=%0d com=%0d cycles=%0d",
                             done_cnt, dv_w[0], idm_w[0], idx_w[0], com_w[0], run_cyc);
                    chk("dna_value", dv_w[0], e.dna);
                    chk("dna_valid", valid_w[0], 1);
                    chk("id_match", idm_w[0], e.idm);
                    chk("match_index", idx_w[0], e.idx);
                    chk("com_enable", com_w[0], e.com);
                    chk_range("busy_cycles", run_cyc, e.cyc - 1, e.cyc + 1);
                end
                done_cnt++;
            end
            busy_prev = busy_w[0];
            dclk_prev = dclk_w[0];
            rd_prev   = rd_w[0];
            sh_prev   = sh_w[0];
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, cyc, base;
        bit seen, fin;
        vec_t v;

        vecs[0] = '{DNA_B, 1'b1, 1'b0, 2'd0, 1'b0, 236};
        vecs[1] = '{DNA_A, 1'b0, 1'b1, 2'd2, 1'b0, 235};
        vecs[2] = '{DNA_A, 1'b1, 1'b1, 2'd2, 1'b1, 235};
        vecs[3] = '{DNA_C, 1'b0, 1'b1, 2'd1, 1'b1, 234};
        model_val[0] = DNA_B;
        model_val[1] = DNA_B;
        model_val[2] = DNA_A;

        repeat (3) @(negedge clk);
        chk("rst_dna_value", dv_w[0], 0);
        chk("rst_dna_valid", valid_w[0], 0);
        chk("rst_id_match", idm_w[0], 0);
        chk("rst_match_index", idx_w[0], 0);
        chk("rst_busy", busy_w[0], 0);
        chk("rst_com_enable", com_w[0], 0);
        chk("rst_led_fault", led_w[0], 0);
        chk("rst_dclk_read_shift", {61'd0, dclk_w[0], rd_w[0], sh_w[0]}, 0);

        // Masked instance: entry 0 differs only in don't-care bits -> one CMP cycle.
        rst_b = 1'b0;
        cyc = 0; seen = 0; fin = 0;
        for (int k = 0; k < 3000 && !fin; k++) begin
            @(negedge clk);
            if (busy_w[2]) begin
                seen = 1;
                cyc++;
            end else if (seen) begin
                fin = 1;
            end
        end
        $display("mask: dna=%h id_match=%0d idx=%0d cycles=%0d", dv_w[2], idm_w[2], idx_w[2], cyc);
        chk("mask_timeout", fin, 1);
        chk("mask_dna_value", dv_w[2], DNA_A);
        chk("mask_id_match", idm_w[2], 1);
        chk("mask_match_index", idx_w[2], 0);
        chk("mask_com_enable", com_w[2], 1);
        chk_range("mask_cycles", cyc, 232, 234);

        for (int i = 0; i < 4; i++) begin
            v = vecs[i];
            model_val[0] = v.model;
            base = done_cnt;
            exp_q.push_back('{v.model, v.idm, v.idx, v.com, v.cyc});
            if (v.use_rst) begin
                @(negedge clk);
                rst0 = 1'b1;
                repeat (2) @(negedge clk);
                rst0 = 1'b0;
            end else begin
                pulse_start();
            end
            wait_done(base);
            count_toggles(0, n);
            $display("vec %0d: model=%h rst=%0d led_toggles=%0d", i, v.model, v.use_rst, n);
            chk("led_blink", n, v.idm ? 0 : 4);
        end

        // start during SHIFT is ignored: exactly one completion.
        model_val[0] = DNA_A;
        base = done_cnt;
        exp_q.push_back('{DNA_A, 1'b1, 2'd2, 1'b1, 235});
        pulse_start();
        for (int k = 0; k < 100 && !sh_w[0]; k++) @(negedge clk);
        chk("shift_reached", sh_w[0], 1);
        repeat (20) @(negedge clk);
        pulse_start();
        wait_done(base);
        repeat (300) @(negedge clk);
        $display("restart-in-shift: completions=%0d busy=%0d", done_cnt - base, busy_w[0]);
        chk("single_done", done_cnt, base + 1);
        chk("idle_after", busy_w[0], 0);

        // rst in the middle of SHIFT, then a clean read afterwards.
        base = done_cnt;
        pulse_start();
        for (int k = 0; k < 100 && !sh_w[0]; k++) @(negedge clk);
        for (int k = 0; k < 400 && shift_rises < 30; k++) @(negedge clk);
        chk("shift_bit30_reached", (shift_rises >= 30) ? 1 : 0, 1);
        rst0 = 1'b1;
        #1;
        $display("midshift rst: busy=%0d com=%0d dclk=%0d", busy_w[0], com_w[0], dclk_w[0]);
        chk("mid_rst_busy", busy_w[0], 0);
        chk("mid_rst_com", com_w[0], 0);
        chk("mid_rst_id_match", idm_w[0], 0);
        chk("mid_rst_idx", idx_w[0], 0);
        chk("mid_rst_dna_value", dv_w[0], 0);
        chk("mid_rst_pins", {61'd0, dclk_w[0], rd_w[0], sh_w[0]}, 0);
        repeat (2) @(negedge clk);
        exp_q.push_back('{DNA_A, 1'b1, 2'd2, 1'b1, 235});
        rst0 = 1'b0;
        wait_done(base);

        // Report-only instance: mismatch but enable forced on, LED still blinks.
        count_toggles(1, n);
        $display("report: dna=%h id_match=%0d com=%0d led_toggles=%0d", dv_w[1], idm_w[1], com_w[1], n);
        chk("rep_dna_valid", valid_w[1], 1);
        chk("rep_dna_value", dv_w[1], DNA_B);
        chk("rep_id_match", idm_w[1], 0);
        chk("rep_com_enable", com_w[1], 1);
        chk("rep_led_blink", n, 4);
        chk("sb_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
